// File: rtl/adder_sweep_driver_if.sv
// rtl/adder_sweep_driver_if.sv - operand/result bus between the sweep driver and the adder under test
interface adder_sweep_driver_if #(
    parameter int W = 2
);
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W:0]   y_in;

    // Driver side: presents operands, observes the adder result
    modport master (
        output a_out,
        output b_out,
        input  y_in
    );

    // Adder side: consumes operands, returns the sum
    modport slave (
        input  a_out,
        input  b_out,
        output y_in
    );
endinterface

// File: rtl/adder_sweep_driver.sv
// rtl/adder_sweep_driver.sv - exhaustive operand sweep and result check for a W-bit adder
module adder_sweep_driver #(
    parameter int W      = 2,
    parameter int SETTLE = 1    // hold cycles before sampling, legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    adder_sweep_driver_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*W:0]         err_cnt,
    output logic [W-1:0]         first_err_a,
    output logic [W-1:0]         first_err_b,
    output logic                 err_seen
);

    localparam int         EW       = 2 * W + 1;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           pass_q, pass_d;
    logic [EW-1:0]  err_cnt_q, err_cnt_d;
    logic [W-1:0]   first_err_a_q, first_err_a_d;
    logic [W-1:0]   first_err_b_q, first_err_b_d;
    logic           err_seen_q, err_seen_d;
    logic [W:0]     expected;

    // Reference sum at full W+1 width so the carry is never lost
    always_comb begin
        expected = {1'b0, a_q} + {1'b0, b_q};
    end

    // Next-state and datapath updates for the sweep sequencer
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        pass_d        = pass_q;
        err_cnt_d     = err_cnt_q;
        first_err_a_d = first_err_a_q;
        first_err_b_d = first_err_b_q;
        err_seen_d    = err_seen_q;

        case (state_q)
            S_IDLE: begin
                a_d = '0;
                b_d = '0;
                if (start) begin
                    err_cnt_d     = '0;
                    err_seen_d    = 1'b0;
                    pass_d        = 1'b0;
                    first_err_a_d = '0;
                    first_err_b_d = '0;
                    cnt_d         = CNT_LOAD;
                    state_d       = S_SETTLE;
                end
            end

            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // Written as match/else so an unknown result lands in the
                // mismatch branch rather than silently skipping it.
                if (bus.y_in == expected) begin
                    err_cnt_d = err_cnt_q;
                end else begin
                    err_cnt_d = err_cnt_q + EW'(1);
                    if (!err_seen_q) begin
                        first_err_a_d = a_q;
                        first_err_b_d = b_q;
                        err_seen_d    = 1'b1;
                    end
                end

                if ((&a_q) && (&b_q)) begin
                    state_d = S_DONE;
                end else begin
                    b_d = b_q + W'(1);
                    if (&b_q) begin
                        a_d = a_q + W'(1);
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end

            S_DONE: begin
                pass_d  = (err_cnt_q == '0);
                a_d     = '0;
                b_d     = '0;
                state_d = S_IDLE;
            end

            default: begin
                a_d     = '0;
                b_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            pass_q        <= 1'b0;
            err_cnt_q     <= '0;
            first_err_a_q <= '0;
            first_err_b_q <= '0;
            err_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            pass_q        <= pass_d;
            err_cnt_q     <= err_cnt_d;
            first_err_a_q <= first_err_a_d;
            first_err_b_q <= first_err_b_d;
            err_seen_q    <= err_seen_d;
        end
    end

    // Status decode and output drive
    always_comb begin
        busy        = (state_q == S_SETTLE) || (state_q == S_CHECK);
        done        = (state_q == S_DONE);
        pass        = pass_q;
        err_cnt     = err_cnt_q;
        first_err_a = first_err_a_q;
        first_err_b = first_err_b_q;
        err_seen    = err_seen_q;
        bus.a_out   = a_q;
        bus.b_out   = b_q;
    end

endmodule

// File: tb/tb_adder_sweep_driver.sv
// tb/tb_adder_sweep_driver.sv - directed self-checking bench for adder_sweep_driver
module tb_adder_sweep_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start3;
    int         mode;       // 0 good adder, 1 bit0 stuck low, 2 two-cycle delayed result

    logic       busy, done, pass, err_seen;
    logic [4:0] err_cnt;
    logic [1:0] first_err_a, first_err_b;

    logic       busy3, done3, pass3, err_seen3;
    logic [4:0] err_cnt3;
    logic [1:0] first_err_a3, first_err_b3;

    int n_checks = 0;
    int n_errors = 0;

    adder_sweep_driver_if #(.W(2)) bus1 ();
    adder_sweep_driver_if #(.W(2)) bus3 ();

    adder_sweep_driver #(.W(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus1.master),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_a(first_err_a), .first_err_b(first_err_b), .err_seen(err_seen)
    );

    adder_sweep_driver #(.W(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bus(bus3.master),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
        .first_err_a(first_err_a3), .first_err_b(first_err_b3), .err_seen(err_seen3)
    );

    always #5 clk = ~clk;

    // Adder models
    logic [2:0] sum1, d1, d2, sum3, e1, e2;
    assign sum1 = {1'b0, bus1.a_out} + {1'b0, bus1.b_out};
    assign sum3 = {1'b0, bus3.a_out} + {1'b0, bus3.b_out};
    always @(posedge clk) begin
        d1 <= sum1;
        d2 <= d1;
        e1 <= sum3;
        e2 <= e1;
    end
    assign bus1.y_in = (mode == 1) ? (sum1 & 3'b110) : (mode == 2) ? d2 : sum1;
    assign bus3.y_in = e2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse (or hold) start and count edges until done; -1 means no done seen
    task automatic run_sweep(input bit trace, input bit repulse, input bit hold, output int edges);
        bit pulsed = 0;
        edges = -1;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (repulse && !pulsed && bus1.a_out == 2'd1 && bus1.b_out == 2'd2) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (trace && i < 32) begin
                check("pair", {28'd0, bus1.a_out, bus1.b_out}, i / 2);
                check("busy_in_sweep", busy, 1);
            end
            if (done) begin
                edges = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int e;
        rst = 1'b1; start = 1'b1; start3 = 1'b0; mode = 0;

        // Reset held with start high
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_pass", pass, 0);
            check("rst_err_cnt", err_cnt, 0);
            check("rst_err_seen", err_seen, 0);
            check("rst_first", {first_err_a, first_err_b}, 0);
            check("rst_ops", {bus1.a_out, bus1.b_out}, 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Correct adder, traced pair order
        run_sweep(1, 0, 0, e);
        check("good_done_edge", e, 32);
        check("good_ops_last", {bus1.a_out, bus1.b_out}, 4'hf);
        check("good_err_cnt", err_cnt, 0);
        check("good_err_seen", err_seen, 0);
        check("good_busy_done", busy, 0);
        @(negedge clk);
        check("good_done_pulse", done, 0);
        check("good_pass", pass, 1);
        check("good_ops_idle", {bus1.a_out, bus1.b_out}, 0);

        // Bit0 stuck low: eight odd sums
        mode = 1;
        run_sweep(0, 0, 0, e);
        check("f0_done_edge", e, 32);
        check("f0_err_cnt", err_cnt, 8);
        check("f0_first_a", first_err_a, 0);
        check("f0_first_b", first_err_b, 1);
        check("f0_err_seen", err_seen, 1);
        @(negedge clk);
        check("f0_pass", pass, 0);

        // Start re-pulsed mid-sweep is ignored
        mode = 0;
        run_sweep(0, 1, 0, e);
        check("repulse_done_edge", e, 32);
        check("repulse_err_cnt", err_cnt, 0);
        @(negedge clk);
        check("repulse_pass", pass, 1);
        check("repulse_no_restart", busy, 0);

        // Start held high: restart one idle cycle after done, counters cleared
        mode = 1;
        run_sweep(0, 0, 1, e);
        check("hold_done_edge", e, 32);
        check("hold_err_cnt", err_cnt, 8);
        start = 1'b1;
        @(negedge clk);
        check("hold_idle_busy", busy, 0);
        check("hold_idle_err_cnt", err_cnt, 8);
        @(negedge clk);
        check("hold_restart_busy", busy, 1);
        check("hold_restart_err_cnt", err_cnt, 0);
        check("hold_restart_seen", err_seen, 0);
        start = 1'b0; mode = 0;
        e = -1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                e = i;
                break;
            end
        end
        check("hold2_done_edge", e, 32);
        check("hold2_err_cnt", err_cnt, 0);

        // Async reset at pair (2,1)
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus1.a_out == 2'd2 && bus1.b_out == 2'd1) break;
            @(negedge clk);
        end
        check("pre_rst_pair", {bus1.a_out, bus1.b_out}, 4'h9);
        mode = 1;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ops", {bus1.a_out, bus1.b_out}, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_err_seen", err_seen, 0);
        mode = 0;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("arst_no_done_after", done, 0);
        run_sweep(0, 0, 0, e);
        check("arst_sweep_edge", e, 32);
        check("arst_sweep_err_cnt", err_cnt, 0);

        // SETTLE=3 against a two-cycle delayed adder
        @(negedge clk);
        start3 = 1'b1;
        e = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (i == 3) check("s3_hold_pair0", {bus3.a_out, bus3.b_out}, 0);
            if (i == 4) check("s3_pair1", {bus3.a_out, bus3.b_out}, 1);
            if (done3) begin
                e = i;
                break;
            end
        end
        check("s3_done_edge", e, 64);
        check("s3_err_cnt", err_cnt3, 0);
        @(negedge clk);
        check("s3_pass", pass3, 1);

        // SETTLE=1 against the same delay: every sum change is missed
        mode = 2;
        run_sweep(0, 0, 0, e);
        check("s1d_done_edge", e, 32);
        check("s1d_err_cnt", err_cnt, 15);
        check("s1d_first", {first_err_a, first_err_b}, 4'h1);
        @(negedge clk);
        check("s1d_pass", pass, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_sweep_driver.md
Name: adder_sweep_driver

Overview:
- Sequential stimulus-and-check stage placed directly upstream of the 2-bit adder block (`a`, `b` in; `y` out).
- On a start request it drives every operand pair to the adder, one pair at a time: `a` is the outer index, `b` the inner index.
- After a settle interval it samples the adder's `y` and compares it against the expected `a+b`.
- It reports an error count, the first failing pair and a pass flag. Intended as an on-chip self-test for the adder.

Parameters:
- `W`, default 2: operand width; the adder result width is `W+1`.
- `SETTLE`, default 1: cycles each pair is held before `y` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; level sampled only in IDLE.
- `a_out`  out  W  operand a to adder.
- `b_out`  out  W  operand b to adder.
- `y_in`  in  W+1  adder result.
- `busy`  out  1  high from the first SETTLE cycle through the last CHECK cycle.
- `done`  out  1  one-cycle pulse marking end of sweep.
- `pass`  out  1  high when the last completed sweep had zero errors; held until next start.
- `err_cnt`  out  2W+1  mismatches in the current or last sweep.
- `first_err_a`  out  W  `a` of the first mismatching pair.
- `first_err_b`  out  W  `b` of the first mismatching pair.
- `err_seen`  out  1  at least one mismatch in the current or last sweep.

Behaviour:
- Reset (async, immediate on `rst`=1): state=IDLE; `a_out`=`b_out`=0; `busy`=`done`=`pass`=`err_seen`=0; `err_cnt`=0; `first_err_a`=`first_err_b`=0; settle counter=0.
- **IDLE:**
  - `busy`=0 and operands are held at 0.
  - When `start`=1 at a clock edge: `a_out`=`b_out`=0, clear `err_cnt`/`err_seen`/`pass`/`first_err`, load settle counter with `SETTLE`, go to SETTLE.
- **SETTLE:**
  - Operands are stable and `busy`=1.
  - The counter decrements every edge; on the edge where it equals 1, go to CHECK. Exactly `SETTLE` cycles are spent in SETTLE.
- **CHECK (1 cycle, `busy`=1):**
  - `expected` = zero-extended `a_out` + zero-extended `b_out`, evaluated at `W+1` bits (no truncation).
  - If `y_in` != `expected`: `err_cnt` += 1. If `err_seen`=0, capture `first_err_a/b` = `a_out/b_out` and set `err_seen`=1.
  - If `a_out` and `b_out` are both all-ones, go to DONE.
  - Otherwise `b_out` += 1; on `b_out` wrap to 0, `a_out` += 1. Reload the counter and go to SETTLE.
- **DONE (1 cycle):**
  - `done`=1, `busy`=0, `pass`=(`err_cnt`==0); then go to IDLE.
  - Operands keep the last pair (all-ones) until the DONE→IDLE edge, then return to 0.
- Latency: `done` is high in the cycle beginning 2^(2W)·(SETTLE+1) edges after the start-sampling edge.
  - Default parameters: `done` appears 32 edges after start.
  - Each pair is held SETTLE+1 cycles, and `y_in` is sampled in the last of them.
- `err_cnt` width `2W+1` holds the maximum 2^(2W); no overflow is possible.
- `start` while `busy` or in DONE: ignored, no restart, no effect on counters.
- `start` held high continuously: a new sweep begins on the edge after DONE→IDLE, i.e. after 1 IDLE cycle.
- Reset mid-sweep: aborts immediately, no `done` pulse, all results cleared.
- `y_in` is treated as combinational from `a_out`/`b_out`; X on `y_in` during CHECK counts as a mismatch in simulation.

Test Plan:
1. **Reset:** assert `rst` for 3 cycles with `start`=1 → all outputs 0, no sweep begins until `rst` falls.
2. **Correct adder model, defaults:** 1-cycle `start` pulse → pairs visited in order (0,0),(0,1),…,(0,3),(1,0),…,(3,3), each for 2 cycles; `done` pulses 32 edges after start → `err_cnt`=0, `pass`=1, `err_seen`=0.
3. **Fault model, `y` bit0 forced to 0:** 8 pairs have an odd sum → `err_cnt`=8, `first_err_a`=0, `first_err_b`=1, `err_seen`=1, `pass`=0.
4. **`start` re-pulsed at pair (1,2):** ignored → sweep completes unchanged at edge 32. **`start` held high:** second sweep begins 1 cycle after `done`, and `err_cnt` is cleared at that point.
5. **Async `rst` mid-cycle at pair (2,1):** outputs return to 0 before the next edge, no `done` pulse; a following start yields a full clean sweep, `done` at edge 32.
6. **`SETTLE`=3, adder model with 2-cycle output delay:** each pair held 4 cycles, `done` at edge 64, `err_cnt`=0. Repeat with `SETTLE`=1 → mismatches reported (nonzero `err_cnt`), `pass`=0.
